// File: rtl/reg_sr_bank_pkg.sv
// rtl/reg_sr_bank_pkg.sv - shared constants and helpers for the filtered set/reset register bank
package reg_sr_bank_pkg;

  localparam int PRIO_CLR  = 0;
  localparam int PRIO_SET  = 1;
  localparam int PRIO_HOLD = 2;

  localparam int FILT_MIN = 1;
  localparam int FILT_MAX = 15;

  // Bits needed to hold counts 0..filt-1; never less than one bit.
  function automatic int cnt_width(input int filt);
    int w;
    w = 1;
    while ((1 << w) < filt) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_sr_bit.sv
// rtl/reg_sr_bit.sv - one register bit with filtered active-low set/clear and sticky conflict flag
module reg_sr_bit
  import reg_sr_bank_pkg::*;
#(
  parameter logic INIT_BIT = 1'b0,
  parameter int   PRIO     = PRIO_CLR,
  parameter int   FILT     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  input  logic set_n,
  input  logic clr_n,
  input  logic conflict_clr,
  output logic q,
  output logic conflict
);

  localparam int            CW      = cnt_width(FILT);
  localparam logic [CW-1:0] CNT_TOP = CW'(FILT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] set_cnt;
  logic [CW-1:0] clr_cnt;
  logic          set_qual;
  logic          clr_qual;
  logic          both_qual;
  logic          q_next;

  // A request qualifies only once its counter has reached the top while still low.
  assign set_qual  = !set_n && (set_cnt == CNT_TOP);
  assign clr_qual  = !clr_n && (clr_cnt == CNT_TOP);
  assign both_qual = set_qual && clr_qual;

  always_comb begin
    q_next = q;
    if (both_qual) begin
      if (PRIO == PRIO_CLR)      q_next = 1'b0;
      else if (PRIO == PRIO_SET) q_next = 1'b1;
      else                       q_next = q;
    end else if (clr_qual) begin
      q_next = 1'b0;
    end else if (set_qual) begin
      q_next = 1'b1;
    end else if (en) begin
      q_next = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_cnt  <= '0;
      clr_cnt  <= '0;
      q        <= INIT_BIT;
      conflict <= 1'b0;
    end else begin
      set_cnt  <= set_n ? '0 : ((set_cnt == CNT_TOP) ? set_cnt : set_cnt + CNT_ONE);
      clr_cnt  <= clr_n ? '0 : ((clr_cnt == CNT_TOP) ? clr_cnt : clr_cnt + CNT_ONE);
      q        <= q_next;
      // A fresh conflict outranks a simultaneous flag clear.
      if (both_qual)         conflict <= 1'b1;
      else if (conflict_clr) conflict <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_sr_bank.sv
// rtl/reg_sr_bank.sv - WIDTH independent filtered set/reset register bits with sticky conflict flags
module reg_sr_bank
  import reg_sr_bank_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               PRIO  = PRIO_CLR,
  parameter int               FILT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] set_n,
  input  logic [WIDTH-1:0] clr_n,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] conflict
);

  if (FILT < FILT_MIN || FILT > FILT_MAX) begin : g_bad_filt
    $error("reg_sr_bank: FILT must be in 1..15");
  end
  if (PRIO < PRIO_CLR || PRIO > PRIO_HOLD) begin : g_bad_prio
    $error("reg_sr_bank: PRIO must be 0, 1 or 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg_sr_bit #(
      .INIT_BIT (INIT[i]),
      .PRIO     (PRIO),
      .FILT     (FILT)
    ) u_bit (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .d            (d[i]),
      .set_n        (set_n[i]),
      .clr_n        (clr_n[i]),
      .conflict_clr (conflict_clr),
      .q            (q[i]),
      .conflict     (conflict[i])
    );
  end

endmodule

// File: tb/tb_reg_sr_bank.sv
// tb/tb_reg_sr_bank.sv - bench for reg_sr_bank across several PRIO/FILT settings
module tb_reg_sr_bank;

  localparam int N = 5;
  localparam int FILT_T [N] = '{1, 1, 1, 3, 4};
  localparam int PRIO_T [N] = '{0, 1, 2, 0, 0};
  localparam logic [7:0] INIT_V = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, en, conflict_clr;
  logic [7:0] d, set_n, clr_n;
  logic [7:0] qs [N];
  logic [7:0] cs [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    reg_sr_bank #(
      .WIDTH (8),
      .INIT  (INIT_V),
      .PRIO  (PRIO_T[g]),
      .FILT  (FILT_T[g])
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .d            (d),
      .set_n        (set_n),
      .clr_n        (clr_n),
      .conflict_clr (conflict_clr),
      .q            (qs[g]),
      .conflict     (cs[g])
    );
  end

  typedef struct packed {
    logic [N-1:0][7:0] q;
    logic [N-1:0][7:0] c;
  } exp_t;

  typedef struct {
    logic       r, e;
    logic [7:0] d, sn, cn;
    logic       cc;
    logic [7:0] eq, ec;
  } vec_t;

  exp_t sb [$];
  logic [7:0] mq [N];
  logic [7:0] mc [N];
  int sc [N][8];
  int cc [N][8];
  int total = 0;
  int passed = 0;
  vec_t tbl [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference behaviour, one bit at a time, straight from the requirements.
  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      for (int b = 0; b < 8; b++) begin
        logic sq, cq;
        sq = !set_n[b] && (sc[k][b] == FILT_T[k] - 1);
        cq = !clr_n[b] && (cc[k][b] == FILT_T[k] - 1);
        if (rst) begin
          mq[k][b] = INIT_V[b];
          mc[k][b] = 1'b0;
          sc[k][b] = 0;
          cc[k][b] = 0;
        end else begin
          if (sq && cq) begin
            if (PRIO_T[k] == 0)      mq[k][b] = 1'b0;
            else if (PRIO_T[k] == 1) mq[k][b] = 1'b1;
          end else if (cq) mq[k][b] = 1'b0;
          else if (sq)     mq[k][b] = 1'b1;
          else if (en)     mq[k][b] = d[b];
          if (sq && cq)          mc[k][b] = 1'b1;
          else if (conflict_clr) mc[k][b] = 1'b0;
          if (set_n[b]) sc[k][b] = 0;
          else if (sc[k][b] < FILT_T[k] - 1) sc[k][b]++;
          if (clr_n[b]) cc[k][b] = 0;
          else if (cc[k][b] < FILT_T[k] - 1) cc[k][b]++;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] dd,
                      input logic [7:0] sn, input logic [7:0] cn, input logic ccl);
    exp_t x;
    rst = r; en = e; d = dd; set_n = sn; clr_n = cn; conflict_clr = ccl;
    model_step();
    for (int k = 0; k < N; k++) begin
      x.q[k] = mq[k];
      x.c[k] = mc[k];
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 8'h00, 8'hFF);
    end else begin
      x = sb.pop_front();
      for (int k = 0; k < N; k++) begin
        check($sformatf("sb_q[%0d]", k), qs[k], x.q[k]);
        check($sformatf("sb_conflict[%0d]", k), cs[k], x.c[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      mq[k] = 8'h00;
      mc[k] = 8'h00;
      for (int b = 0; b < 8; b++) begin
        sc[k][b] = 0;
        cc[k][b] = 0;
      end
    end
    rst = 1'b1; en = 1'b0; d = 8'h00; set_n = 8'hFF; clr_n = 8'hFF; conflict_clr = 1'b0;

    // Expectations for instance 0 (FILT=1, clear wins).
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'hA5, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'hA5, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'h3C, 8'hFF, 8'hFF, 1'b0, 8'h3C, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h3C, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 8'hFE, 8'hFF, 1'b0, 8'h3D, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hDF, 1'b0, 8'h1D, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'hFB, 8'hFB, 1'b0, 8'h19, 8'h04};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 8'h7F, 8'hFF, 1'b0, 8'h80, 8'h04};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 8'h80, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'hF7, 8'hF7, 1'b1, 8'h80, 8'h08};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 8'h80, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b0, 8'hFE, 8'h00};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].sn, tbl[i].cn, tbl[i].cc);
      check($sformatf("tbl_q row %0d", i), qs[0], tbl[i].eq);
      check($sformatf("tbl_conflict row %0d", i), cs[0], tbl[i].ec);
    end

    // Conflict policy, first from q[2]=0 then from q[2]=1.
    step(1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hFB, 8'hFB, 1'b0);
    check("prio_clr q2 from 0", {7'd0, qs[0][2]}, 8'h00);
    check("prio_set q2 from 0", {7'd0, qs[1][2]}, 8'h01);
    check("prio_hold q2 from 0", {7'd0, qs[2][2]}, 8'h00);
    for (int k = 0; k < 3; k++) check($sformatf("prio conflict2 [%0d]", k), {7'd0, cs[k][2]}, 8'h01);
    step(1'b0, 1'b1, 8'h04, 8'hFF, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hFB, 8'hFB, 1'b0);
    check("prio_clr q2 from 1", {7'd0, qs[0][2]}, 8'h00);
    check("prio_set q2 from 1", {7'd0, qs[1][2]}, 8'h01);
    check("prio_hold q2 from 1", {7'd0, qs[2][2]}, 8'h01);

    // FILT=3: bit0 low three cycles qualifies, bit1 low two cycles does not.
    step(1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hFC, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hFC, 8'hFF, 1'b0);
    check("filt3 after 2 low", qs[3], 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'hFE, 8'hFF, 1'b0);
    check("filt3 after 3 low", qs[3], 8'h01);
    step(1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);
    check("filt3 released", qs[3], 8'h01);

    // FILT=4: reset mid-filter restarts the clear count.
    step(1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hFF, 8'hEF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hFF, 8'hEF, 1'b0);
    step(1'b1, 1'b0, 8'h00, 8'hFF, 8'hEF, 1'b0);
    check("filt4 reset value", qs[4], INIT_V);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hEF, 1'b0);
      check($sformatf("filt4 post-reset low %0d", i + 1), qs[4], 8'hFF);
    end
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hEF, 1'b0);
    check("filt4 post-reset low 4", qs[4], 8'hEF);

    // Held set overrides load; release lets the load through.
    step(1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00, 8'hDF, 8'hFF, 1'b0);
      check($sformatf("override hold %0d", i), qs[0], 8'h20);
    end
    step(1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0);
    check("override release", qs[0], 8'h00);

    // Sticky flag: new conflict beats a simultaneous clear.
    step(1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 8'hF7, 1'b0);
    check("sticky set", cs[0], 8'h08);
    step(1'b0, 1'b0, 8'h00, 8'hF7, 8'hF7, 1'b1);
    check("sticky race", cs[0], 8'h08);
    step(1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1);
    check("sticky clear", cs[0], 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_sr_bank.md
REG_SR_BANK -- requirements
Module: reg_sr_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of register bits.
REQ-002 SHALL have parameter INIT, default all-zero (WIDTH bits): value loaded on reset.
REQ-003 SHALL have parameter PRIO, default 0: conflict policy. 0 = clear wins, 1 = set wins, 2 = hold current value.
REQ-004 SHALL have parameter FILT, default 1, range 1..15: consecutive low cycles a set/clear request needs before it qualifies.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit: load enable for d.
REQ-008 SHALL have port d, input, WIDTH bits: data to load.
REQ-009 SHALL have port set_n, input, WIDTH bits: per-bit set request, active-low.
REQ-010 SHALL have port clr_n, input, WIDTH bits: per-bit clear request, active-low.
REQ-011 SHALL have port conflict_clr, input, 1 bit: clears all sticky conflict flags.
REQ-012 SHALL have port q, output, WIDTH bits: registered value.
REQ-013 SHALL have port conflict, output, WIDTH bits: per-bit sticky conflict flags.

Function
REQ-014 Per bit, a set counter SHALL increment while set_n[i]=0, saturate at FILT-1, and return to 0 in any cycle set_n[i]=1; the clear counter on clr_n[i] SHALL behave the same way.
REQ-015 A set request SHALL be qualified in a cycle where set_n[i]=0 and its counter equals FILT-1; FILT=1 therefore qualifies in the first low cycle, and clear requests qualify by the same rule.
REQ-016 Next q[i] SHALL follow this priority: rst gives INIT[i]; else a qualified conflict applies PRIO; else a qualified clear gives 0; else a qualified set gives 1; else en=1 gives d[i]; else q[i] holds.
REQ-017 A held request SHALL stay qualified every cycle while it remains low; the override persists and en/d are ignored for that bit.
REQ-018 Latency SHALL be: d to q, 1 cycle; request to q, FILT cycles after the first low cycle.
REQ-019 conflict[i] SHALL set on the edge ending any cycle in which set and clear are both qualified for bit i, for every PRIO value.
REQ-020 conflict_clr=1 SHALL clear all conflict flags on the next edge; a new conflict in the same cycle SHALL win for that bit.
REQ-021 Bits SHALL be fully independent; no bit's request affects another bit.
REQ-022 Outputs SHALL be driven directly from flops, with no combinational path from input to output.

Reset
REQ-023 While rst=1 at an edge: q SHALL become INIT, conflict SHALL become 0, and all counters SHALL become 0.
REQ-024 rst SHALL override en, requests and conflict_clr; requests held across reset deassertion SHALL count from 0 starting in the first cycle with rst=0.
REQ-025 No asynchronous set or reset path SHALL exist, and there SHALL be no simulation-only force/release logic.

Structure
REQ-026 The shared package SHALL hold the PRIO encodings (PRIO_CLR=0, PRIO_SET=1, PRIO_HOLD=2) and a function giving counter width from FILT.
REQ-027 One sub-module, reg_sr_bit, SHALL implement a single bit (both counters, q flop, conflict flop); reg_sr_bank SHALL instantiate it WIDTH times via generate.
REQ-028 Parameter checks SHALL be done at elaboration: FILT outside 1..15, or PRIO greater than 2, is an elaboration error.

Verification
REQ-029 Reset/load: WIDTH=8, INIT=8'hA5; rst for 2 cycles gives q=8'hA5; then en=1, d=8'h3C for 1 cycle gives q=8'h3C one cycle later, and en=0 holds it.
REQ-030 Filter: FILT=3, set_n[0] low 3 cycles gives q[0]=1 after the 3rd edge; set_n[1] low 2 cycles then high leaves q[1] unchanged.
REQ-031 Conflict policy: FILT=1, set_n[2]=clr_n[2]=0 for one cycle gives q[2]=0 for PRIO=0, q[2]=1 for PRIO=1, and q[2] unchanged for PRIO=2; conflict[2]=1 in all cases.
REQ-032 Sticky clear race: conflict[3]=1; conflict_clr=1 in the same cycle as a new bit-3 conflict keeps conflict[3]=1; conflict_clr alone the next cycle clears it to 0.
REQ-033 Reset mid-filter: FILT=4, clr_n[4] low 2 cycles, then rst for 1 cycle with clr_n[4] kept low; q[4] clears only after 4 further low cycles following reset release.
REQ-034 Override vs load: set_n[5] held low with en=1, d[5]=0 gives q[5]=1 throughout; releasing set_n[5] gives q[5]=0 on the next edge.
